datamem_responder: RTL

DATAMEM_RESPONDER -- requirements
Module: datamem_responder

---
 rtl/datamem_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/datamem_responder.sv
// Multi-cycle data memory for the M stage. Each request is captured, held for LATENCY wait
// cycles, executed, and then answered with a one-cycle ReadyM pulse.
module datamem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ReqM,
    input  logic                  MemWriteM,
    input  logic [2:0]            funct3M,
    input  logic [31:0]           ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  ReadyM,
    output logic                  ErrM,
    output logic                  StallM
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  write_q;
    logic [2:0]            funct3_q;
    logic [IW+1:0]         addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  capture;
    logic                  execute;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] word;
    logic [7:0]            ldByte;
    logic [15:0]           ldHalf;
    logic                  accErr;
    logic [DATA_WIDTH-1:0] loadData;
    logic [DATA_WIDTH-1:0] storeMask;
    logic [DATA_WIDTH-1:0] storeData;
    logic                  unused_addr;

    // Address bits above the array span are ignored, so accesses wrap modulo DEPTH*4.
    assign unused_addr = ^ALUResultM[31:IW+2];

    assign capture = (state_q == IDLE) && ReqM;
    assign execute = (state_q == WAIT) && (cnt_q == '0);

    assign StallM    = ReqM && (state_q != DONE);
    assign ReadyM    = (state_q == DONE);
    assign ReadDataM = rdata_q;
    assign ErrM      = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (capture) begin
                write_q  <= MemWriteM;
                funct3_q <= funct3M;
                addr_q   <= ALUResultM[IW+1:0];
                wdata_q  <= WriteDataM;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ReqM) begin
                    state_d = WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access decode on the captured request; only meaningful when execute is high.
    always_comb begin
        shamt  = {addr_q[1:0], 3'b000};
        word   = mem[addr_q[IW+1:2]];
        ldByte = word[shamt +: 8];
        ldHalf = word[{addr_q[1], 4'b0000} +: 16];

        accErr = 1'b0;
        case (funct3_q)
            3'b000:         accErr = 1'b0;
            3'b001:         accErr = addr_q[0];
            3'b010:         accErr = |addr_q[1:0];
            3'b100:         accErr = write_q;
            3'b101:         accErr = write_q | addr_q[0];
            default:        accErr = 1'b1;
        endcase

        loadData = '0;
        case (funct3_q)
            3'b000:  loadData = {{(DATA_WIDTH-8){ldByte[7]}}, ldByte};
            3'b001:  loadData = {{(DATA_WIDTH-16){ldHalf[15]}}, ldHalf};
            3'b010:  loadData = word;
            3'b100:  loadData = {{(DATA_WIDTH-8){1'b0}}, ldByte};
            3'b101:  loadData = {{(DATA_WIDTH-16){1'b0}}, ldHalf};
            default: loadData = '0;
        endcase

        storeData = wdata_q << shamt;
        storeMask = '0;
        case (funct3_q[1:0])
            2'b00:   storeMask = DATA_WIDTH'(8'hFF) << shamt;
            2'b01:   storeMask = DATA_WIDTH'(16'hFFFF) << shamt;
            2'b10:   storeMask = '1;
            default: storeMask = '0;
        endcase

        rdata_d = rdata_q;
        err_d   = err_q;
        if (execute) begin
            err_d   = accErr;
            rdata_d = (write_q || accErr) ? '0 : loadData;
        end
    end

    // The array has no reset; an abandoned access never reaches execute because
    // the reset forces the FSM back to IDLE.
    always_ff @(posedge clk) begin
        if (execute && write_q && !accErr) begin
            mem[addr_q[IW+1:2]] <= (word & ~storeMask) | (storeData & storeMask);
        end
    end

endmodule
